// File: rtl/recovery_pkg.sv
// Shared types, default widths and helpers for the recovery checkpoint file.
package recovery_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned POP_MAX    = 256;

    typedef enum logic [1:0] {StIdle, StStream, StDone} restore_state_e;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/recovery_restore_fsm.sv
// Restore sequencer: walks the pointer over every entry with a valid/ready stream.
module recovery_restore_fsm
    import recovery_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              restore_start,
    input  logic              rcv_ready,
    output logic              rcv_valid,
    output logic [ADDR_W-1:0] rcv_addr,
    output logic              rcv_last,
    output logic              busy,
    output logic              restore_done,
    output logic              beat_fire,
    output logic              stream_end
);

    restore_state_e    state;
    logic [ADDR_W-1:0] ptr_inc;

    assign ptr_inc    = rcv_addr + ADDR_W'(1);
    assign beat_fire  = rcv_valid & rcv_ready;
    assign stream_end = beat_fire & rcv_last;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state        <= StIdle;
            rcv_addr     <= '0;
            rcv_valid    <= 1'b0;
            rcv_last     <= 1'b0;
            busy         <= 1'b0;
            restore_done <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    restore_done <= 1'b0;
                    if (restore_start) begin
                        state     <= StStream;
                        rcv_addr  <= '0;
                        rcv_valid <= 1'b1;
                        rcv_last  <= (ADDR_W == 0);
                        busy      <= 1'b1;
                    end
                end
                StStream: begin
                    if (rcv_ready) begin
                        if (rcv_last) begin
                            state        <= StDone;
                            rcv_valid    <= 1'b0;
                            rcv_last     <= 1'b0;
                            restore_done <= 1'b1;
                        end else begin
                            rcv_addr <= ptr_inc;
                            rcv_last <= &ptr_inc;
                        end
                    end
                end
                StDone: begin
                    state        <= StIdle;
                    restore_done <= 1'b0;
                    busy         <= 1'b0;
                end
                default: begin
                    state        <= StIdle;
                    rcv_valid    <= 1'b0;
                    busy         <= 1'b0;
                    restore_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/recovery_checkpoint_file.sv
// Working + committed register banks with dirty tracking and a checkpoint restore stream.
module recovery_checkpoint_file
    import recovery_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              ckpt,
    input  logic              restore_start,
    output logic              rcv_valid,
    input  logic              rcv_ready,
    output logic [ADDR_W-1:0] rcv_addr,
    output logic [DATA_W-1:0] rcv_data,
    output logic              rcv_last,
    output logic              busy,
    output logic              restore_done,
    output logic [ADDR_W:0]   dirty_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] working_q   [DEPTH];
    logic [DATA_W-1:0] committed_q [DEPTH];
    logic [DEPTH-1:0]  dirty_q, dirty_d;
    logic              beat_fire, stream_end;
    logic              wr_ok, ckpt_ok;

    recovery_restore_fsm #(
        .ADDR_W (ADDR_W)
    ) u_fsm (
        .clk           (clk),
        .rst_in        (rst_in),
        .restore_start (restore_start),
        .rcv_ready     (rcv_ready),
        .rcv_valid     (rcv_valid),
        .rcv_addr      (rcv_addr),
        .rcv_last      (rcv_last),
        .busy          (busy),
        .restore_done  (restore_done),
        .beat_fire     (beat_fire),
        .stream_end    (stream_end)
    );

    // A restore request wins over a same-cycle write or checkpoint.
    assign wr_ok   = wr_en && !busy && !restore_start && !((ZERO_REG != 0) && (wr_addr == '0));
    assign ckpt_ok = ckpt && !busy && !restore_start;

    assign rd_data  = working_q[rd_addr];
    assign rcv_data = committed_q[rcv_addr];

    always_comb begin
        dirty_d = dirty_q;
        if (wr_ok) begin
            dirty_d[wr_addr] = 1'b1;
        end
        if (ckpt_ok || stream_end) begin
            dirty_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                working_q[i]   <= '0;
                committed_q[i] <= '0;
            end
            dirty_q   <= '0;
            dirty_cnt <= '0;
        end else begin
            if (wr_ok) begin
                working_q[wr_addr] <= wr_data;
            end
            if (beat_fire) begin
                working_q[rcv_addr] <= committed_q[rcv_addr];
            end
            if (ckpt_ok) begin
                for (int i = 0; i < DEPTH; i++) begin
                    committed_q[i] <= (wr_ok && (wr_addr == ADDR_W'(i))) ? wr_data : working_q[i];
                end
            end
            dirty_q   <= dirty_d;
            dirty_cnt <= (ADDR_W + 1)'(popcount(POP_MAX'(dirty_d)));
        end
    end

endmodule

// File: tb/tb_recovery_checkpoint_file.sv
// Randomised directed bench for recovery_checkpoint_file against an array-based model.
module tb_recovery_checkpoint_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst_in, wr_en, ckpt, restore_start, rcv_ready;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data, rcv_data;
    logic          rcv_valid, rcv_last, busy, restore_done;
    logic [AW-1:0] rcv_addr;
    logic [AW:0]   dirty_cnt;

    // Reference model: the two banks and the set of dirty entries.
    logic [DW-1:0] m_work [N];
    logic [DW-1:0] m_comm [N];
    bit   [N-1:0]  m_dirty;

    int total = 0;
    int bad   = 0;

    recovery_checkpoint_file dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .ckpt          (ckpt),
        .restore_start (restore_start),
        .rcv_valid     (rcv_valid),
        .rcv_ready     (rcv_ready),
        .rcv_addr      (rcv_addr),
        .rcv_data      (rcv_data),
        .rcv_last      (rcv_last),
        .busy          (busy),
        .restore_done  (restore_done),
        .dirty_cnt     (dirty_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_work[i] = '0;
            m_comm[i] = '0;
        end
        m_dirty = '0;
    endtask

    task automatic m_write(input int a, input logic [DW-1:0] d);
        if (a != 0) begin
            m_work[a]  = d;
            m_dirty[a] = 1'b1;
        end
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        m_write(a, d);
    endtask

    task automatic do_ckpt();
        ckpt = 1'b1;
        tick();
        ckpt = 1'b0;
        m_comm  = m_work;
        m_dirty = '0;
    endtask

    task automatic check_reads(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_addr = AW'(i);
            #1;
            chk(tag, rd_data, m_work[i]);
        end
        chk({tag, "_dirty"}, dirty_cnt, $countones(m_dirty));
    endtask

    // mode 0: ready always high; 1: random ready plus junk inputs; 2: ready pattern 1,0,0,1.
    // abort_at >= 0 applies a reset when that beat is presented.
    task automatic run_stream(input int mode, input int abort_at);
        int e;
        int cyc;
        logic r;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        e = 0;
        cyc = 0;
        while (e < N && cyc < 1000) begin
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = ($urandom_range(0, 2) != 0);
            else                r = pat[cyc % 4];
            rcv_ready = r;
            if (mode != 0) begin
                wr_en         = 1'($urandom_range(0, 1));
                wr_addr       = AW'($urandom);
                wr_data       = $urandom;
                ckpt          = 1'($urandom_range(0, 1));
                restore_start = 1'($urandom_range(0, 1));
            end
            #1;
            chk("beat_valid", rcv_valid, 1'b1);
            chk("beat_addr", rcv_addr, e);
            chk("beat_data", rcv_data, m_comm[e]);
            chk("beat_last", rcv_last, e == N - 1);
            if (e == abort_at) begin
                wr_en = 1'b0; ckpt = 1'b0; restore_start = 1'b0;
                rst_in = 1'b1;
                tick();
                rst_in = 1'b0;
                rcv_ready = 1'b0;
                m_reset();
                return;
            end
            tick();
            if (r) e++;
            cyc++;
        end
        wr_en = 1'b0; ckpt = 1'b0; restore_start = 1'b0; rcv_ready = 1'b0;
        if (cyc >= 1000) chk("stream_timeout", e, N);
        chk("done_pulse", restore_done, 1'b1);
        chk("done_valid", rcv_valid, 1'b0);
        chk("done_busy", busy, 1'b1);
        tick();
        chk("done_fall", restore_done, 1'b0);
        chk("busy_fall", busy, 1'b0);
        m_work  = m_comm;
        m_dirty = '0;
    endtask

    task automatic do_restore(input int mode);
        restore_start = 1'b1;
        tick();
        restore_start = 1'b0;
        run_stream(mode, -1);
    endtask

    initial begin
        rst_in = 1'b1; wr_en = 1'b0; ckpt = 1'b0; restore_start = 1'b0; rcv_ready = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        m_reset();
        tick();
        tick();
        rst_in = 1'b0;
        chk("rst_valid", rcv_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", restore_done, 1'b0);
        chk("rst_rcv_data", rcv_data, 0);
        check_reads("rst_rd");

        // Basic writes and the hardwired zero entry.
        do_write(1, 32'h3);
        do_write(2, 32'h9);
        rd_addr = 5'd1;
        #1;
        chk("rd_e1", rd_data, 32'h3);
        do_write(0, 32'hFFFF_FFFF);
        rd_addr = 5'd0;
        #1;
        chk("rd_e0", rd_data, 32'h0);
        chk("dirty_two", dirty_cnt, 2);

        // Checkpoint then overwrite, restore brings back the snapshot.
        do_write(3, 32'd15);
        do_ckpt();
        chk("ckpt_dirty", dirty_cnt, 0);
        do_write(3, 32'd99);
        do_restore(0);
        rd_addr = 5'd3;
        #1;
        chk("restored_e3", rd_data, 32'd15);
        check_reads("post_restore");

        // Stalled stream with junk inputs ignored.
        do_write(4, 32'h1234);
        do_restore(2);
        check_reads("post_stall");

        // Write and checkpoint in the same cycle.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5; ckpt = 1'b1;
        tick();
        wr_en = 1'b0; ckpt = 1'b0;
        m_write(5, 32'hA5);
        m_comm  = m_work;
        m_dirty = '0;
        chk("wrckpt_dirty", dirty_cnt, 0);
        do_restore(0);
        check_reads("post_wrckpt");

        // Random writes, checkpoint, more writes, random-stall restore.
        for (int k = 0; k < 20; k++) begin
            do_write(int'($urandom_range(0, N - 1)), $urandom);
            chk("rand_dirty", dirty_cnt, $countones(m_dirty));
        end
        check_reads("rand_rd");
        do_ckpt();
        for (int k = 0; k < 8; k++) do_write(int'($urandom_range(0, N - 1)), $urandom);
        do_restore(1);
        check_reads("post_rand");

        // Reset in the middle of a stream.
        restore_start = 1'b1;
        tick();
        restore_start = 1'b0;
        run_stream(0, 10);
        chk("abort_valid", rcv_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", restore_done, 1'b0);
        tick();
        chk("abort_done2", restore_done, 1'b0);
        check_reads("abort_rd");

        // Dirty count on rewrite, then ckpt dropped by same-cycle restore_start.
        do_write(9, 32'h77);
        do_ckpt();
        do_write(7, 32'h11);
        do_write(7, 32'h22);
        do_write(8, 32'h33);
        chk("rewrite_dirty", dirty_cnt, 2);
        ckpt = 1'b1;
        restore_start = 1'b1;
        tick();
        ckpt = 1'b0;
        restore_start = 1'b0;
        run_stream(0, -1);
        check_reads("ckpt_dropped");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
